// File: rtl/leds_racer_pkg.sv
// Shared types and constants for the racer LED stream: decoder states and
// the GRB pixel layout used by both the frame generator and the decoder.
package leds_racer_pkg;

   typedef enum logic [1:0] {
      ST_SYNC,
      ST_IDLE,
      ST_HIGH,
      ST_LOW
   } dec_state_e;

   localparam int PIXEL_W = 24;
   localparam int BYTE_W  = 8;
   localparam int G_LSB   = 16;
   localparam int R_LSB   = 8;
   localparam int B_LSB   = 0;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/leds_line_sync.sv
// Two-flop synchronizer for the asynchronous LED line, plus one-cycle
// rise/fall strobes derived from the synchronized level.
module leds_line_sync (
   input  logic clk,
   input  logic force_reset,
   input  logic leds_line,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk) begin
      if (force_reset) begin
         meta   <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta   <= leds_line;
         sync_q <= meta;
         prev_q <= sync_q;
      end
   end

   assign level = sync_q;
   assign rise  = sync_q & ~prev_q;
   assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/leds_line_decoder.sv
// WS2812-style line decoder: pulse-width bit slicing, 24-bit GRB pixel
// assembly and latch-gap frame detection. Optional: LEDS_LINE_DECODER_GLITCH_FILTER_EN.
module leds_line_decoder
   import leds_racer_pkg::*;
#(
   parameter int MAX_POS           = 109,
   parameter int BIT_THRESHOLD_CLK = 15,
   parameter int LATCH_CLK_CNT     = 1250,
   parameter int MIN_HIGH_CLK      = 3
) (
   input  logic                        clk,
   input  logic                        force_reset,
   input  logic                        leds_line,
   output logic [PIXEL_W-1:0]          pixel_data,
   output logic [$clog2(MAX_POS)-1:0]  pixel_index,
   output logic                        pixel_valid,
   output logic                        frame_done,
   output logic                        frame_error
);

   localparam int IDX_W   = $clog2(MAX_POS);
   localparam int PC_W    = $clog2(MAX_POS + 1);
   localparam int BC_W    = $clog2(PIXEL_W);
   localparam int CNT_MAX = max3(LATCH_CLK_CNT, BIT_THRESHOLD_CLK, MIN_HIGH_CLK);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   logic level, rise, fall;

   leds_line_sync u_sync (
      .clk         (clk),
      .force_reset (force_reset),
      .leds_line   (leds_line),
      .level       (level),
      .rise        (rise),
      .fall        (fall)
   );

   dec_state_e           state, state_n;
   logic [CNT_W-1:0]     high_cnt, high_n, high_inc;
   logic [CNT_W-1:0]     low_cnt, low_n, low_inc;
   logic [BC_W-1:0]      bit_cnt, bits_n;
   logic [PC_W-1:0]      pix_cnt, pix_n;
   logic [PIXEL_W-2:0]   shreg, sh_n;
   logic [PIXEL_W-1:0]   data_n;
   logic [IDX_W-1:0]     idx_n;
   logic                 valid_n, done_n, err_n;
   logic                 bit_val, glitch, glitch_to_low;

`ifdef LEDS_LINE_DECODER_GLITCH_FILTER_EN
   // A frame is in progress once any bit has been accepted since the last latch.
   assign glitch        = high_cnt < CNT_W'(MIN_HIGH_CLK);
   assign glitch_to_low = (bit_cnt != '0) || (pix_cnt != '0);
`else
   assign glitch        = 1'b0;
   assign glitch_to_low = 1'b0;
`endif

   assign high_inc = (high_cnt == CNT_W'(CNT_MAX)) ? high_cnt : high_cnt + CNT_W'(1);
   assign low_inc  = (low_cnt  == CNT_W'(CNT_MAX)) ? low_cnt  : low_cnt  + CNT_W'(1);
   assign bit_val  = high_cnt >= CNT_W'(BIT_THRESHOLD_CLK);

   always_ff @(posedge clk) begin
      if (force_reset) begin
         state       <= ST_SYNC;
         high_cnt    <= '0;
         low_cnt     <= '0;
         bit_cnt     <= '0;
         pix_cnt     <= '0;
         shreg       <= '0;
         pixel_data  <= '0;
         pixel_index <= '0;
         pixel_valid <= 1'b0;
         frame_done  <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         state       <= state_n;
         high_cnt    <= high_n;
         low_cnt     <= low_n;
         bit_cnt     <= bits_n;
         pix_cnt     <= pix_n;
         shreg       <= sh_n;
         pixel_data  <= data_n;
         pixel_index <= idx_n;
         pixel_valid <= valid_n;
         frame_done  <= done_n;
         frame_error <= err_n;
      end
   end

   always_comb begin
      state_n = state;
      high_n  = high_cnt;
      low_n   = low_cnt;
      bits_n  = bit_cnt;
      pix_n   = pix_cnt;
      sh_n    = shreg;
      data_n  = pixel_data;
      idx_n   = pixel_index;
      valid_n = 1'b0;
      done_n  = 1'b0;
      err_n   = frame_error;

      case (state)
         ST_SYNC: begin
            if (level) begin
               low_n = '0;
            end else if (low_inc >= CNT_W'(LATCH_CLK_CNT)) begin
               low_n   = '0;
               state_n = ST_IDLE;
            end else begin
               low_n = low_inc;
            end
         end

         ST_IDLE: begin
            // The rising cycle itself is the first high clock of the pulse.
            if (rise) begin
               state_n = ST_HIGH;
               high_n  = CNT_W'(1);
            end
         end

         ST_HIGH: begin
            if (!fall) begin
               high_n = high_inc;
            end else if (glitch) begin
               state_n = glitch_to_low ? ST_LOW : ST_IDLE;
               low_n   = low_inc;
            end else begin
               state_n = ST_LOW;
               low_n   = CNT_W'(1);
               if (bit_cnt == BC_W'(PIXEL_W - 1)) begin
                  bits_n = '0;
                  if (pix_cnt == PC_W'(MAX_POS)) begin
                     err_n = 1'b1;
                  end else begin
                     data_n  = {shreg, bit_val};
                     idx_n   = pix_cnt[IDX_W-1:0];
                     valid_n = 1'b1;
                     pix_n   = pix_cnt + PC_W'(1);
                  end
               end else begin
                  sh_n   = {shreg[PIXEL_W-3:0], bit_val};
                  bits_n = bit_cnt + BC_W'(1);
               end
            end
         end

         ST_LOW: begin
            if (rise) begin
               state_n = ST_HIGH;
               high_n  = CNT_W'(1);
            end else if (low_inc >= CNT_W'(LATCH_CLK_CNT)) begin
               // Latch gap: close the frame, dropping any partial pixel.
               state_n = ST_IDLE;
               done_n  = 1'b1;
               low_n   = '0;
               bits_n  = '0;
               pix_n   = '0;
               if (bit_cnt != '0) err_n = 1'b1;
            end else begin
               low_n = low_inc;
            end
         end

         default: state_n = ST_SYNC;
      endcase
   end

endmodule

// File: tb/tb_leds_line_decoder.sv
// Directed bench for leds_line_decoder: single-pixel vector table plus
// hand-written frame, overflow, partial-pixel, reset and glitch sequences.
module tb_leds_line_decoder;

   localparam int LATCH = 1250;

   logic        clk = 1'b0;
   logic        force_reset;
   logic        leds_line;
   logic [23:0] pixel_data;
   logic [6:0]  pixel_index;
   logic        pixel_valid;
   logic        frame_done;
   logic        frame_error;

   int n_chk  = 0;
   int n_fail = 0;

   leds_line_decoder dut (
      .clk         (clk),
      .force_reset (force_reset),
      .leds_line   (leds_line),
      .pixel_data  (pixel_data),
      .pixel_index (pixel_index),
      .pixel_valid (pixel_valid),
      .frame_done  (frame_done),
      .frame_error (frame_error)
   );

   always #5 clk = ~clk;

   // Monitor: record every strobe, sampled on the falling edge.
   logic [23:0] data_q[$];
   logic [6:0]  idx_q[$];
   int          fd_cnt = 0;

   always @(negedge clk) begin
      if (pixel_valid) begin
         data_q.push_back(pixel_data);
         idx_q.push_back(pixel_index);
      end
      if (frame_done) fd_cnt++;
   end

   typedef struct {
      logic [23:0] tx;
      int          one_w;
      int          zero_w;
      int          low_w;
      logic [23:0] exp;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input int hw, input int lw);
      leds_line = 1'b1;
      repeat (hw) tick();
      leds_line = 1'b0;
      repeat (lw) tick();
   endtask

   task automatic send_bits(input logic [23:0] d, input int hi, input int lo,
                            input int one_w, input int zero_w, input int low_w);
      for (int i = hi; i >= lo; i--) send_bit(d[i] ? one_w : zero_w, low_w);
   endtask

   task automatic gap();
      leds_line = 1'b0;
      repeat (LATCH + 20) tick();
   endtask

   task automatic do_reset();
      force_reset = 1'b1;
      leds_line   = 1'b0;
      repeat (3) tick();
      force_reset = 1'b0;
   endtask

   int qb, fb;

   initial begin
      vecs[0] = '{24'hFF0000, 20,   10, 10, 24'hFF0000};
      vecs[1] = '{24'hA5C30F, 15,   14,  3, 24'hA5C30F};
      vecs[2] = '{24'hFFFFFF, 14,    4,  2, 24'h000000};
      vecs[3] = '{24'h000000, 20,   15,  2, 24'hFFFFFF};
      vecs[4] = '{24'h800000, 1300,  4,  1, 24'h800000};
      vecs[5] = '{24'h3C5AA5, 16,    3,  1, 24'h3C5AA5};

      force_reset = 1'b1;
      leds_line   = 1'b0;
      repeat (3) tick();
      chk("rst_data",  pixel_data,  0);
      chk("rst_index", pixel_index, 0);
      chk("rst_valid", pixel_valid, 0);
      chk("rst_done",  frame_done,  0);
      chk("rst_error", frame_error, 0);
      force_reset = 1'b0;

      gap();
      chk("sync_no_done",  fd_cnt,      0);
      chk("sync_no_pixel", data_q.size(), 0);

      for (int v = 0; v < 6; v++) begin
         qb = data_q.size();
         fb = fd_cnt;
         send_bits(vecs[v].tx, 23, 0, vecs[v].one_w, vecs[v].zero_w, vecs[v].low_w);
         gap();
         chk($sformatf("vec%0d_count", v), data_q.size() - qb, 1);
         if (data_q.size() > qb) begin
            chk($sformatf("vec%0d_data", v),  data_q[qb], vecs[v].exp);
            chk($sformatf("vec%0d_index", v), idx_q[qb],  0);
         end
         chk($sformatf("vec%0d_done", v),  fd_cnt - fb,  1);
         chk($sformatf("vec%0d_error", v), frame_error, 0);
      end

      // Full frame: pixel n carries n in every byte.
      qb = data_q.size();
      fb = fd_cnt;
      for (int n = 0; n < 109; n++) send_bits({3{n[7:0]}}, 23, 0, 15, 4, 1);
      gap();
      chk("full_count", data_q.size() - qb, 109);
      for (int n = 0; n < 109 && qb + n < data_q.size(); n++) begin
         chk($sformatf("full_data%0d", n),  data_q[qb+n], {3{n[7:0]}});
         chk($sformatf("full_index%0d", n), idx_q[qb+n],  n);
      end
      chk("full_done",  fd_cnt - fb, 1);
      chk("full_error", frame_error, 0);

      // Partial pixel at the latch.
      qb = data_q.size();
      fb = fd_cnt;
      send_bits(24'h000ABC, 11, 0, 15, 4, 1);
      gap();
      chk("part_count", data_q.size() - qb, 0);
      chk("part_done",  fd_cnt - fb, 1);
      chk("part_error", frame_error, 1);

      qb = data_q.size();
      for (int n = 0; n < 3; n++) send_bits({3{n[7:0]}} ^ 24'h5A5A5A, 23, 0, 15, 4, 1);
      gap();
      chk("after_part_count", data_q.size() - qb, 3);
      for (int n = 0; n < 3 && qb + n < data_q.size(); n++) begin
         chk($sformatf("after_part_data%0d", n),  data_q[qb+n], {3{n[7:0]}} ^ 24'h5A5A5A);
         chk($sformatf("after_part_index%0d", n), idx_q[qb+n],  n);
      end

      // Overlong frame: 110 pixels.
      do_reset();
      gap();
      chk("ovf_pre_error", frame_error, 0);
      qb = data_q.size();
      fb = fd_cnt;
      for (int n = 0; n < 110; n++) send_bits(24'h000000, 23, 0, 15, 4, 1);
      gap();
      chk("ovf_count", data_q.size() - qb, 109);
      chk("ovf_error", frame_error, 1);
      chk("ovf_done",  fd_cnt - fb, 1);

      // Reset during pixel 3.
      qb = data_q.size();
      for (int n = 0; n < 3; n++) send_bits({3{n[7:0]}}, 23, 0, 15, 4, 1);
      send_bits(24'h030303, 23, 14, 15, 4, 1);
      chk("mid_count", data_q.size() - qb, 3);
      force_reset = 1'b1;
      tick();
      force_reset = 1'b0;
      chk("mid_rst_data",  pixel_data,  0);
      chk("mid_rst_index", pixel_index, 0);
      chk("mid_rst_valid", pixel_valid, 0);
      chk("mid_rst_done",  frame_done,  0);
      chk("mid_rst_error", frame_error, 0);

      // Pulses before the SYNC gap completes must produce nothing.
      qb = data_q.size();
      fb = fd_cnt;
      send_bits(24'hFFFFFF, 23, 0, 15, 4, 1);
      chk("sync_hold_count", data_q.size() - qb, 0);
      chk("sync_hold_done",  fd_cnt - fb, 0);
      gap();
      chk("sync_hold_done2", fd_cnt - fb, 0);
      send_bits(24'h5A5A5A, 23, 0, 15, 4, 1);
      gap();
      chk("post_rst_count", data_q.size() - qb, 1);
      if (data_q.size() > qb) begin
         chk("post_rst_data",  data_q[qb], 24'h5A5A5A);
         chk("post_rst_index", idx_q[qb],  0);
      end
      chk("post_rst_done", fd_cnt - fb, 1);

`ifdef LEDS_LINE_DECODER_GLITCH_FILTER_EN
      qb = data_q.size();
      send_bits(24'hC33C96, 23, 12, 15, 4, 2);
      send_bit(2, 2);
      send_bits(24'hC33C96, 11, 0, 15, 4, 2);
      gap();
      chk("glitch_count", data_q.size() - qb, 1);
      if (data_q.size() > qb) begin
         chk("glitch_data",  data_q[qb], 24'hC33C96);
         chk("glitch_index", idx_q[qb],  0);
      end
      chk("glitch_error", frame_error, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
